// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RISC-V control FSM:
// opcode constants, state encoding and datapath mux select codes.
package multicycle_control_fsm_pkg;

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_ECALL    = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  // register write-back source
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // PC source
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;

  // ALU A source
  localparam logic [1:0] SRCA_PC     = 2'd0;
  localparam logic [1:0] SRCA_RS1    = 2'd1;
  localparam logic [1:0] SRCA_OLD_PC = 2'd2;

  // ALU B source
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  // ALU control class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-cycle counter with optional timeout.
//   clk, reset : clock, async active-low reset
//   en         : FSM is in a wait state and memory is not ready
//   timeout    : this cycle is the MEM_TIMEOUT-th unserved wait cycle
// The count clears whenever en is low, so every wait state starts from 0.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TIMEOUT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic timeout
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            count <= '0;
    else if (!en)          count <= '0;
    else if (count != CNT_MAX) count <= count + TIMEOUT_W'(1);
  end

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      // count holds the wait cycles already spent; this one is number count+1
      localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(MEM_TIMEOUT - 1);
      assign timeout = en && (count >= LIMIT);
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/multicycle_control_fsm.sv
// Control FSM for the multi-cycle RISC-V datapath.
//   inputs : part_of_inst (opcode from IR), mem_ready, bcond, halt_req
//   outputs: PC/memory/IR/regfile enables, mux selects, alu_op,
//            status is_ecall, halted, sticky illegal_inst and mem_err
// Outputs decode the registered state; only IF's ir_write/pc_write
// depend on mem_ready in the same cycle.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int ALU_OP_W      = 2,
  parameter int MEM_TIMEOUT   = 0,
  parameter int TIMEOUT_W     = 8,
  parameter bit ECALL_HALT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          part_of_inst,
  input  logic                mem_ready,
  input  logic                bcond,
  input  logic                halt_req,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          wb_sel,
  output logic [1:0]          pc_source,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                reg_write,
  output logic                is_ecall,
  output logic                halted,
  output logic                illegal_inst,
  output logic                mem_err
);

  state_t state;
  logic   waiting, timeout;
  logic   unused_bcond;

  // bcond qualifies pc_write_cond inside the datapath, not here
  assign unused_bcond = bcond;

  assign waiting = (state == S_IF || state == S_MEM_RD || state == S_MEM_WR) && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TIMEOUT_W   (TIMEOUT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (waiting),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IF;
      illegal_inst <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      case (state)
        S_IF: begin
          if (mem_ready) state <= S_ID;
          else if (timeout) begin
            mem_err <= 1'b1;
            state   <= S_HALT;
          end
        end
        S_ID: begin
          case (part_of_inst)
            OP_LOAD, OP_STORE: state <= S_MEM_ADDR;
            OP_ARITH:          state <= S_EXEC_R;
            OP_ARITH_IMM:      state <= S_EXEC_I;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_JALR:           state <= S_JALR;
            OP_ECALL:          state <= S_ECALL;
            default: begin
              illegal_inst <= 1'b1;
              state        <= S_IF;
            end
          endcase
        end
        S_MEM_ADDR: state <= (part_of_inst == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (mem_ready) state <= S_MEM_WB;
          else if (timeout) begin
            mem_err <= 1'b1;
            state   <= S_HALT;
          end
        end
        S_MEM_WR: begin
          if (mem_ready) state <= S_IF;
          else if (timeout) begin
            mem_err <= 1'b1;
            state   <= S_HALT;
          end
        end
        S_EXEC_R, S_EXEC_I: state <= S_ALU_WB;
        S_ECALL:  state <= (ECALL_HALT_EN && halt_req) ? S_HALT : S_IF;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IF;  // MEM_WB, ALU_WB, BRANCH, JAL, JALR
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    wb_sel        = WB_ALUOUT;
    pc_source     = PCS_ALU;
    alu_op        = ALU_OP_W'(ALUOP_ADD);
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    reg_write     = 1'b0;
    is_ecall      = 1'b0;
    halted        = 1'b0;
    case (state)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_ID: begin
        // precompute old_pc + imm into ALUOut for branch/JAL targets
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_MDR;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_OP_W'(ALUOP_FUNCT);
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OP_W'(ALUOP_FUNCT);
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = SRCA_RS1;
        alu_op        = ALU_OP_W'(ALUOP_BR);
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
      end
      S_JAL: begin
        // PC already holds PC+4 from IF, so it is the link value
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_source = PCS_ALUOUT;
      end
      S_JALR: begin
        // rd and PC update on the same edge: rd captures the old PC (PC+4)
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        wb_sel    = WB_PC;
      end
      S_ECALL:  is_ecall = 1'b1;
      S_HALT:   halted   = 1'b1;
      default: ;
    endcase
  end

endmodule
